// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: ALU opcodes, ARM condition codes,
// multiplier FSM states and flag bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100,
    ALU_MOV = 3'b101,
    ALU_MUL = 3'b110,
    ALU_RSV = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/execute_stage_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per RUN cycle,
// low SIZE bits of the product held in result_o until the next start.
module mul_iter
  import cpu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [SIZE-1:0] result_o
);

  localparam int CW = $clog2(SIZE + 1);

  mul_state_e      state_q, state_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_RUN;
      MUL_RUN:  if (cnt_q == CW'(SIZE - 1)) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Operands are latched at start so upstream changes during RUN are ignored.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    if (state_q == MUL_IDLE && start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      prod_d = '0;
      cnt_d  = '0;
    end else if (state_q == MUL_RUN) begin
      if (b_q[0]) prod_d = prod_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    busy_o   = (state_q == MUL_RUN) || (state_q == MUL_IDLE && start_i);
    done_o   = (state_q == MUL_DONE);
    result_o = prod_q;
  end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding, ALU, ARM condition evaluation,
// flag register and condition-gated control outputs.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PCSrcE,
  input  logic            RegWriteE,
  input  logic            MemToRegE,
  input  logic            MemToWriteE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            FlagWriteE,
  input  logic [2:0]      ALUControlE,
  input  logic [3:0]      CondE,
  input  logic [3:0]      WA3E,
  input  logic [SIZE-1:0] RE1,
  input  logic [SIZE-1:0] RE2,
  input  logic [SIZE-1:0] ExtImmE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [SIZE-1:0] ALUResultM,
  input  logic [SIZE-1:0] ResultW,
  output logic [SIZE-1:0] ALUResultE,
  output logic [SIZE-1:0] WriteDataE,
  output logic            PCSrcOut,
  output logic            RegWriteOut,
  output logic            MemWriteOut,
  output logic            BranchTakenE,
  output logic            MemToRegOut,
  output logic [3:0]      WA3Out,
  output logic [3:0]      FlagsOut,
  output logic            MulBusyE
);

  alu_op_e         op_w;
  logic [SIZE-1:0] src_a, src_b, alu_b, alu_res, mul_res;
  logic [SIZE:0]   sum_w;
  logic [3:0]      flags_q, flags_d;
  logic            c_new, v_new, cond_ex, mul_start, mul_busy, mul_done, flag_we, gate;
  logic            fn, fz, fc, fv;

  assign op_w = alu_op_e'(ALUControlE);

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RE1;
    endcase
    case (ForwardBE)
      2'b01:   src_b = ResultW;
      2'b10:   src_b = ALUResultM;
      default: src_b = RE2;
    endcase
    alu_b = ALUSrcE ? ExtImmE : src_b;
  end

  always_comb begin
    fn = flags_q[N_BIT];
    fz = flags_q[Z_BIT];
    fc = flags_q[C_BIT];
    fv = flags_q[V_BIT];
    case (cond_e'(CondE))
      COND_EQ: cond_ex = fz;
      COND_NE: cond_ex = !fz;
      COND_CS: cond_ex = fc;
      COND_CC: cond_ex = !fc;
      COND_MI: cond_ex = fn;
      COND_PL: cond_ex = !fn;
      COND_VS: cond_ex = fv;
      COND_VC: cond_ex = !fv;
      COND_HI: cond_ex = fc && !fz;
      COND_LS: cond_ex = !fc || fz;
      COND_GE: cond_ex = (fn == fv);
      COND_LT: cond_ex = (fn != fv);
      COND_GT: cond_ex = !fz && (fn == fv);
      COND_LE: cond_ex = fz || (fn != fv);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Reset holds off a new multiply so busy is low as soon as RST is seen.
  assign mul_start = (op_w == ALU_MUL) && cond_ex && !RST;

  mul_iter #(.SIZE(SIZE)) u_mul (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (mul_start),
    .a_i     (src_a),
    .b_i     (src_b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .result_o(mul_res)
  );

  always_comb begin
    alu_res = '0;
    sum_w   = '0;
    c_new   = flags_q[C_BIT];
    v_new   = flags_q[V_BIT];
    case (op_w)
      ALU_ADD: begin
        sum_w   = {1'b0, src_a} + {1'b0, alu_b};
        alu_res = sum_w[SIZE-1:0];
        c_new   = sum_w[SIZE];
        v_new   = (src_a[SIZE-1] == alu_b[SIZE-1]) && (alu_res[SIZE-1] != src_a[SIZE-1]);
      end
      ALU_SUB: begin
        sum_w   = {1'b0, src_a} + {1'b0, ~alu_b} + (SIZE+1)'(1);
        alu_res = sum_w[SIZE-1:0];
        c_new   = sum_w[SIZE];
        v_new   = (src_a[SIZE-1] != alu_b[SIZE-1]) && (alu_res[SIZE-1] != src_a[SIZE-1]);
      end
      ALU_AND: alu_res = src_a & alu_b;
      ALU_ORR: alu_res = src_a | alu_b;
      ALU_EOR: alu_res = src_a ^ alu_b;
      ALU_MOV: alu_res = alu_b;
      ALU_MUL: alu_res = mul_res;
      default: alu_res = '0;
    endcase
  end

  // A multiply only commits flags in its DONE cycle.
  assign flag_we = FlagWriteE && cond_ex && !mul_busy && (op_w != ALU_RSV) &&
                   ((op_w != ALU_MUL) || mul_done);

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d[N_BIT] = alu_res[SIZE-1];
      flags_d[Z_BIT] = (alu_res == '0);
      flags_d[C_BIT] = c_new;
      flags_d[V_BIT] = v_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  assign gate         = cond_ex && !mul_busy && !RST;
  assign PCSrcOut     = PCSrcE && gate;
  assign RegWriteOut  = RegWriteE && gate;
  assign MemWriteOut  = MemToWriteE && gate;
  assign BranchTakenE = BranchE && gate;
  assign MemToRegOut  = MemToRegE;
  assign WA3Out       = WA3E;
  assign FlagsOut     = flags_q;
  assign MulBusyE     = mul_busy;
  assign ALUResultE   = alu_res;
  assign WriteDataE   = src_b;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops,
// hand sequences for multiply timing, reset abort and never-condition.
module tb_execute_stage;

  logic        CLK, RST;
  logic        PCSrcE, RegWriteE, MemToRegE, MemToWriteE, BranchE, ALUSrcE, FlagWriteE;
  logic [2:0]  ALUControlE;
  logic [3:0]  CondE, WA3E;
  logic [31:0] RE1, RE2, ExtImmE, ALUResultM, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultE, WriteDataE;
  logic        PCSrcOut, RegWriteOut, MemWriteOut, BranchTakenE, MemToRegOut, MulBusyE;
  logic [3:0]  WA3Out, FlagsOut;

  int checks = 0;
  int errors = 0;

  execute_stage #(.SIZE(32)) dut (
    .CLK(CLK), .RST(RST), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .MemToWriteE(MemToWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .FlagWriteE(FlagWriteE),
    .ALUControlE(ALUControlE), .CondE(CondE), .WA3E(WA3E), .RE1(RE1), .RE2(RE2),
    .ExtImmE(ExtImmE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUResultM(ALUResultM),
    .ResultW(ResultW), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCSrcOut(PCSrcOut),
    .RegWriteOut(RegWriteOut), .MemWriteOut(MemWriteOut), .BranchTakenE(BranchTakenE),
    .MemToRegOut(MemToRegOut), .WA3Out(WA3Out), .FlagsOut(FlagsOut), .MulBusyE(MulBusyE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] re1, re2, imm, alum, resw;
    logic        alusrc;
    logic [2:0]  op;
    logic [3:0]  cond;
    logic        fw, ctrl;
    logic [31:0] exp_res, exp_wd;
    logic        exp_gate;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] re1, input logic [31:0] re2,
                              input logic [31:0] imm, input logic [31:0] alum,
                              input logic [31:0] resw, input logic alusrc,
                              input logic [2:0] op, input logic [3:0] cond,
                              input logic fw, input logic ctrl,
                              input logic [31:0] exp_res, input logic [31:0] exp_wd,
                              input logic exp_gate, input logic [3:0] exp_flags);
    vec_t v;
    v.fa = fa; v.fb = fb; v.re1 = re1; v.re2 = re2; v.imm = imm; v.alum = alum;
    v.resw = resw; v.alusrc = alusrc; v.op = op; v.cond = cond; v.fw = fw; v.ctrl = ctrl;
    v.exp_res = exp_res; v.exp_wd = exp_wd; v.exp_gate = exp_gate; v.exp_flags = exp_flags;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_ctrl(input logic c);
    PCSrcE = c; RegWriteE = c; MemToWriteE = c; BranchE = c;
  endtask

  task automatic set_defaults();
    set_ctrl(1'b0);
    MemToRegE = 1'b1; WA3E = 4'h5; ALUSrcE = 1'b0; FlagWriteE = 1'b0;
    ALUControlE = 3'b000; CondE = 4'b1110; RE1 = '0; RE2 = '0; ExtImmE = '0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUResultM = '0; ResultW = '0;
  endtask

  task automatic check_gates(input string nm, input logic exp);
    chk({nm, ".pcsrc"}, PCSrcOut, exp);
    chk({nm, ".regwrite"}, RegWriteOut, exp);
    chk({nm, ".memwrite"}, MemWriteOut, exp);
    chk({nm, ".branch"}, BranchTakenE, exp);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    ForwardAE = v.fa; ForwardBE = v.fb; RE1 = v.re1; RE2 = v.re2; ExtImmE = v.imm;
    ALUResultM = v.alum; ResultW = v.resw; ALUSrcE = v.alusrc; ALUControlE = v.op;
    CondE = v.cond; FlagWriteE = v.fw; set_ctrl(v.ctrl);
    @(negedge CLK);
    chk({nm, ".result"}, ALUResultE, v.exp_res);
    chk({nm, ".wdata"}, WriteDataE, v.exp_wd);
    check_gates(nm, v.exp_gate);
    @(posedge CLK); #1;
    chk({nm, ".flags"}, FlagsOut, v.exp_flags);
  endtask

  // Called just after a posedge with the FSM idle; returns just after the DONE posedge.
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_prod, input logic [3:0] exp_flags,
                         input logic toggle);
    int busy_cnt;
    ForwardAE = 2'b00; ForwardBE = 2'b00; RE1 = a; RE2 = b; ALUSrcE = 1'b0;
    ALUControlE = 3'b110; CondE = 4'b1110; FlagWriteE = 1'b1; set_ctrl(1'b1);
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!MulBusyE) break;
      busy_cnt++;
      if (c == 0) check_gates({nm, ".busy_gate"}, 1'b0);
      @(posedge CLK); #1;
      if (toggle) begin
        RE1 = $urandom; RE2 = $urandom_range(0, 255);
      end
    end
    chk({nm, ".busy_cycles"}, busy_cnt, 33);
    chk({nm, ".product"}, ALUResultE, exp_prod);
    chk({nm, ".done_regwrite"}, RegWriteOut, 1'b1);
    @(posedge CLK); #1;
    chk({nm, ".flags"}, FlagsOut, exp_flags);
    set_defaults();
  endtask

  logic rw_seen;

  initial begin
    // Vectors; flag state carries over from one row to the next.
    vecs[0]  = mk(2'b00, 2'b00, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 3'b000, 4'hE, 1, 1, 32'h80000000, 32'h1, 1, 4'h9);
    vecs[1]  = mk(2'b00, 2'b00, 32'h5, 32'h5, 0, 0, 0, 0, 3'b001, 4'hE, 1, 1, 32'h0, 32'h5, 1, 4'h6);
    vecs[2]  = mk(2'b00, 2'b00, 32'h5, 32'h5, 0, 0, 0, 0, 3'b001, 4'h0, 0, 1, 32'h0, 32'h5, 1, 4'h6);
    vecs[3]  = mk(2'b00, 2'b00, 32'h5, 32'h5, 0, 0, 0, 0, 3'b001, 4'h1, 0, 1, 32'h0, 32'h5, 0, 4'h6);
    vecs[4]  = mk(2'b10, 2'b01, 32'h1, 32'h2, 0, 32'h10, 32'h20, 0, 3'b000, 4'hE, 0, 1, 32'h30, 32'h20, 1, 4'h6);
    vecs[5]  = mk(2'b11, 2'b01, 32'h100, 32'h2, 0, 32'h10, 32'h20, 0, 3'b000, 4'hE, 0, 1, 32'h120, 32'h20, 1, 4'h6);
    vecs[6]  = mk(2'b00, 2'b00, 32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 3'b010, 4'hE, 1, 1, 32'hF0, 32'h0FF0, 1, 4'h2);
    vecs[7]  = mk(2'b00, 2'b00, 32'h80000000, 32'h1, 0, 0, 0, 0, 3'b011, 4'hE, 1, 1, 32'h80000001, 32'h1, 1, 4'hA);
    vecs[8]  = mk(2'b00, 2'b00, 32'hFF, 32'hFF, 0, 0, 0, 0, 3'b100, 4'hE, 1, 1, 32'h0, 32'hFF, 1, 4'h6);
    vecs[9]  = mk(2'b00, 2'b00, 32'h5, 32'hDEAD, 32'h1234, 0, 0, 1, 3'b101, 4'hE, 1, 1, 32'h1234, 32'hDEAD, 1, 4'h2);
    vecs[10] = mk(2'b00, 2'b00, 32'h5, 32'h6, 0, 0, 0, 0, 3'b111, 4'hE, 1, 1, 32'h0, 32'h6, 1, 4'h2);
    vecs[11] = mk(2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 3'b000, 4'hE, 1, 1, 32'h0, 32'h1, 1, 4'h6);
    vecs[12] = mk(2'b00, 2'b00, 32'h3, 32'h5, 0, 0, 0, 0, 3'b001, 4'hE, 1, 1, 32'hFFFFFFFE, 32'h5, 1, 4'h8);
    vecs[13] = mk(2'b00, 2'b00, 32'h1, 32'h1, 0, 0, 0, 0, 3'b000, 4'h4, 0, 1, 32'h2, 32'h1, 1, 4'h8);
    vecs[14] = mk(2'b00, 2'b00, 32'h2, 32'h2, 0, 0, 0, 0, 3'b000, 4'hA, 1, 1, 32'h4, 32'h2, 0, 4'h8);
    vecs[15] = mk(2'b00, 2'b00, 32'h2, 32'h2, 0, 0, 0, 0, 3'b000, 4'hF, 1, 1, 32'h4, 32'h2, 0, 4'h8);
    vecs[16] = mk(2'b00, 2'b00, 32'h2, 32'h2, 0, 0, 0, 0, 3'b000, 4'hB, 0, 1, 32'h4, 32'h2, 1, 4'h8);

    // Reset with a live ADD presented: gated outputs must stay low.
    set_defaults();
    set_ctrl(1'b1);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset.flags", FlagsOut, 4'h0);
    chk("reset.busy", MulBusyE, 1'b0);
    check_gates("reset", 1'b0);
    chk("reset.wa3", WA3Out, 4'h5);
    chk("reset.memtoreg", MemToRegOut, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b0;
    set_defaults();

    for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

    // Multiply with operand toggling, then back-to-back multiply.
    run_mul("mul7x6", 32'd7, 32'd6, 32'd42, 4'h0, 1'b1);
    run_mul("mul_b2b", 32'h10000, 32'h10000, 32'h0, 4'h4, 1'b0);

    // Reset asserted during RUN aborts the multiply.
    rw_seen = 1'b0;
    RE1 = 32'd3; RE2 = 32'd4; ALUControlE = 3'b110; CondE = 4'hE; FlagWriteE = 1'b1;
    set_ctrl(1'b1);
    @(negedge CLK);
    chk("rstmul.start_busy", MulBusyE, 1'b1);
    rw_seen = rw_seen | RegWriteOut;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      rw_seen = rw_seen | RegWriteOut;
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_gates("rstmul.in_reset", 1'b0);
    rw_seen = rw_seen | RegWriteOut;
    @(posedge CLK); #1;
    RST = 1'b0;
    set_defaults();
    @(negedge CLK);
    chk("rstmul.busy", MulBusyE, 1'b0);
    chk("rstmul.flags", FlagsOut, 4'h0);
    chk("rstmul.no_regwrite", rw_seen, 1'b0);
    @(posedge CLK); #1;
    run_mul("mul_after_rst", 32'd3, 32'd5, 32'd15, 4'h0, 1'b0);

    // Never-condition MUL is a one-cycle bubble.
    apply_vec(mk(2'b00, 2'b00, 32'h3, 32'h5, 0, 0, 0, 0, 3'b001, 4'hE, 1, 1, 32'hFFFFFFFE, 32'h5, 1, 4'h8), 99);
    RE1 = 32'd9; RE2 = 32'd9; ALUControlE = 3'b110; CondE = 4'hF; FlagWriteE = 1'b1;
    set_ctrl(1'b1);
    @(negedge CLK);
    chk("mulnv.busy", MulBusyE, 1'b0);
    check_gates("mulnv", 1'b0);
    @(posedge CLK); #1;
    chk("mulnv.flags", FlagsOut, 4'h8);
    @(negedge CLK);
    chk("mulnv.busy_next", MulBusyE, 1'b0);
    set_defaults();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
